// File: rtl/decode_issue_buffer_pkg.sv
// Shared RV32I decode constants, op ids, unit / ROB type codes and the decoded-entry record.
package decode_issue_buffer_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam int OPID_BITS = 6;
    typedef logic [OPID_BITS-1:0] op_id_t;

    localparam op_id_t OP_NOP   = 6'd0;
    localparam op_id_t OP_LUI   = 6'd1;
    localparam op_id_t OP_AUIPC = 6'd2;
    localparam op_id_t OP_JAL   = 6'd3;
    localparam op_id_t OP_JALR  = 6'd4;
    localparam op_id_t OP_BEQ   = 6'd5;
    localparam op_id_t OP_BNE   = 6'd6;
    localparam op_id_t OP_BLT   = 6'd7;
    localparam op_id_t OP_BGE   = 6'd8;
    localparam op_id_t OP_BLTU  = 6'd9;
    localparam op_id_t OP_BGEU  = 6'd10;
    localparam op_id_t OP_LB    = 6'd11;
    localparam op_id_t OP_LH    = 6'd12;
    localparam op_id_t OP_LW    = 6'd13;
    localparam op_id_t OP_LBU   = 6'd14;
    localparam op_id_t OP_LHU   = 6'd15;
    localparam op_id_t OP_SB    = 6'd16;
    localparam op_id_t OP_SH    = 6'd17;
    localparam op_id_t OP_SW    = 6'd18;
    localparam op_id_t OP_ADDI  = 6'd19;
    localparam op_id_t OP_SLTI  = 6'd20;
    localparam op_id_t OP_SLTIU = 6'd21;
    localparam op_id_t OP_XORI  = 6'd22;
    localparam op_id_t OP_ORI   = 6'd23;
    localparam op_id_t OP_ANDI  = 6'd24;
    localparam op_id_t OP_SLLI  = 6'd25;
    localparam op_id_t OP_SRLI  = 6'd26;
    localparam op_id_t OP_SRAI  = 6'd27;
    localparam op_id_t OP_ADD   = 6'd28;
    localparam op_id_t OP_SUB   = 6'd29;
    localparam op_id_t OP_SLL   = 6'd30;
    localparam op_id_t OP_SLT   = 6'd31;
    localparam op_id_t OP_SLTU  = 6'd32;
    localparam op_id_t OP_XOR   = 6'd33;
    localparam op_id_t OP_SRL   = 6'd34;
    localparam op_id_t OP_SRA   = 6'd35;
    localparam op_id_t OP_OR    = 6'd36;
    localparam op_id_t OP_AND   = 6'd37;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ALU  = 2'd1,
        UNIT_BR   = 2'd2,
        UNIT_LSB  = 2'd3
    } unit_e;

    typedef enum logic [2:0] {
        ROB_REG    = 3'd0,
        ROB_BRANCH = 3'd1,
        ROB_STORE  = 3'd2,
        ROB_LOAD   = 3'd3,
        ROB_JUMP   = 3'd4,
        ROB_EXC    = 3'd5
    } rob_type_e;

    typedef struct packed {
        unit_e      unit;
        op_id_t     op_id;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_we;
        rob_type_e  rob_type;
        logic       illegal;
    } entry_t;

endpackage

// File: rtl/decode_issue_buffer_decode.sv
// Pure combinational RV32I decoder: instruction word + pc -> decoded buffer entry.
module inst_decode_comb
    import decode_issue_buffer_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output entry_t      entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;
    logic        legal;
    logic        writes_rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        entry     = '0;
        entry.pc  = pc;
        legal     = 1'b1;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                entry.unit  = UNIT_ALU;
                entry.op_id = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
                entry.imm   = imm_u;
                writes_rd   = 1'b1;
            end
            OPC_JAL: begin
                entry.unit     = UNIT_BR;
                entry.op_id    = OP_JAL;
                entry.imm      = imm_j;
                entry.rob_type = ROB_JUMP;
                writes_rd      = 1'b1;
            end
            OPC_JALR: begin
                entry.unit     = UNIT_BR;
                entry.op_id    = OP_JALR;
                entry.imm      = imm_i;
                entry.rs1      = inst[19:15];
                entry.rob_type = ROB_JUMP;
                writes_rd      = 1'b1;
                legal          = (funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                entry.unit     = UNIT_BR;
                entry.imm      = imm_b;
                entry.rs1      = inst[19:15];
                entry.rs2      = inst[24:20];
                entry.rob_type = ROB_BRANCH;
                case (funct3)
                    F3_BEQ:  entry.op_id = OP_BEQ;
                    F3_BNE:  entry.op_id = OP_BNE;
                    F3_BLT:  entry.op_id = OP_BLT;
                    F3_BGE:  entry.op_id = OP_BGE;
                    F3_BLTU: entry.op_id = OP_BLTU;
                    F3_BGEU: entry.op_id = OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                entry.unit     = UNIT_LSB;
                entry.imm      = imm_i;
                entry.rs1      = inst[19:15];
                entry.rob_type = ROB_LOAD;
                writes_rd      = 1'b1;
                case (funct3)
                    F3_LB:   entry.op_id = OP_LB;
                    F3_LH:   entry.op_id = OP_LH;
                    F3_LW:   entry.op_id = OP_LW;
                    F3_LBU:  entry.op_id = OP_LBU;
                    F3_LHU:  entry.op_id = OP_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                entry.unit     = UNIT_LSB;
                entry.imm      = imm_s;
                entry.rs1      = inst[19:15];
                entry.rs2      = inst[24:20];
                entry.rob_type = ROB_STORE;
                case (funct3)
                    F3_SB:   entry.op_id = OP_SB;
                    F3_SH:   entry.op_id = OP_SH;
                    F3_SW:   entry.op_id = OP_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                entry.unit = UNIT_ALU;
                entry.imm  = imm_i;
                entry.rs1  = inst[19:15];
                writes_rd  = 1'b1;
                case (funct3)
                    F3_ADD_SUB: entry.op_id = OP_ADDI;
                    F3_SLT:     entry.op_id = OP_SLTI;
                    F3_SLTU:    entry.op_id = OP_SLTIU;
                    F3_XOR:     entry.op_id = OP_XORI;
                    F3_OR:      entry.op_id = OP_ORI;
                    F3_AND:     entry.op_id = OP_ANDI;
                    F3_SLL: begin
                        entry.op_id = OP_SLLI;
                        entry.imm   = imm_sh;
                        legal       = (funct7 == F7_BASE);
                    end
                    default: begin
                        // funct3 = SRL/SRA: funct7 picks logical vs arithmetic
                        entry.op_id = (funct7 == F7_ALT) ? OP_SRAI : OP_SRLI;
                        entry.imm   = imm_sh;
                        legal       = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                entry.unit = UNIT_ALU;
                entry.rs1  = inst[19:15];
                entry.rs2  = inst[24:20];
                writes_rd  = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: entry.op_id = OP_ADD;
                        F3_SLL:     entry.op_id = OP_SLL;
                        F3_SLT:     entry.op_id = OP_SLT;
                        F3_SLTU:    entry.op_id = OP_SLTU;
                        F3_XOR:     entry.op_id = OP_XOR;
                        F3_SRL_SRA: entry.op_id = OP_SRL;
                        F3_OR:      entry.op_id = OP_OR;
                        default:    entry.op_id = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    entry.op_id = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    entry.op_id = OP_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (writes_rd) begin
            entry.rd = inst[11:7];
        end
        entry.rd_we = writes_rd && (inst[11:7] != 5'd0);

        // Illegal words still occupy a ROB slot so the exception surfaces at commit.
        if (!legal) begin
            entry          = '0;
            entry.pc       = pc;
            entry.rob_type = ROB_EXC;
            entry.illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_buffer.sv
// Decode stage: decodes accepted IQ words into a small in-order circular buffer and
// issues the head once the ROB and its target reservation station have space.
module decode_issue_buffer
    import decode_issue_buffer_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int OPID_W = 6,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              iq_valid,
    input  logic [31:0]       iq_inst,
    input  logic [31:0]       iq_pc,
    output logic              iq_ready,
    input  logic              alu_full,
    input  logic              br_full,
    input  logic              lsb_full,
    input  logic              rob_full,
    input  logic [TAG_W-1:0]  rob_tag,
    output logic              issue_fire,
    output logic [1:0]        issue_unit,
    output logic [OPID_W-1:0] issue_op_id,
    output logic [31:0]       issue_pc,
    output logic [31:0]       issue_imm,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [4:0]        issue_rd,
    output logic [4:0]        issue_rs1,
    output logic [4:0]        issue_rs2,
    output logic              issue_rd_we,
    output logic [2:0]        issue_rob_type,
    output logic              issue_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DEPTH-1:0] valid_reg, valid_next;
    entry_t           entry_mem [DEPTH];

    entry_t dec_entry;
    entry_t head_entry;
    logic   unit_busy;
    logic   push;
    logic   pop;
    logic   clear;

    inst_decode_comb u_decode (
        .inst  (iq_inst),
        .pc    (iq_pc),
        .entry (dec_entry)
    );

    assign head_entry = entry_mem[head_reg];

    always_comb begin
        unit_busy = 1'b0;
        case (head_entry.unit)
            UNIT_ALU: unit_busy = alu_full;
            UNIT_BR:  unit_busy = br_full;
            UNIT_LSB: unit_busy = lsb_full;
            default:  unit_busy = 1'b0;
        endcase
    end

    // Readiness uses the registered count, so a slot freed by this cycle's issue is not reused.
    assign iq_ready = rst & rdy & ~flush & (count_reg < CNT_W'(DEPTH));
    assign push     = iq_valid & iq_ready;
    assign pop      = rst & rdy & ~flush & (count_reg != '0) & valid_reg[head_reg]
                      & ~rob_full & ~unit_busy;
    assign clear    = rdy & flush;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = tail_reg + 1'b1;
            end
            if (pop) begin
                head_next = head_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_next[gi] = clear                                   ? 1'b0 :
                                    (push && tail_reg == PTR_W'(gi))        ? 1'b1 :
                                    (pop && head_reg == PTR_W'(gi))         ? 1'b0 :
                                    valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[tail_reg] <= dec_entry;
        end
    end

    assign issue_fire     = pop;
    assign issue_unit     = pop ? head_entry.unit : UNIT_NONE;
    assign issue_op_id    = pop ? OPID_W'(head_entry.op_id) : '0;
    assign issue_pc       = pop ? head_entry.pc : '0;
    assign issue_imm      = pop ? head_entry.imm : '0;
    assign issue_tag      = pop ? rob_tag : '0;
    assign issue_rd       = pop ? head_entry.rd : '0;
    assign issue_rs1      = pop ? head_entry.rs1 : '0;
    assign issue_rs2      = pop ? head_entry.rs2 : '0;
    assign issue_rd_we    = pop & head_entry.rd_we;
    assign issue_rob_type = pop ? head_entry.rob_type : ROB_REG;
    assign issue_illegal  = pop & head_entry.illegal;

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_decode_issue_buffer;
    import decode_issue_buffer_pkg::*;

    localparam int TAG_W  = 4;
    localparam int OPID_W = 6;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
    logic              flush = 1'b0;
    logic              iq_valid = 1'b0;
    logic [31:0]       iq_inst = '0;
    logic [31:0]       iq_pc = '0;
    logic              iq_ready;
    logic              alu_full = 1'b0;
    logic              br_full = 1'b0;
    logic              lsb_full = 1'b0;
    logic              rob_full = 1'b0;
    logic [TAG_W-1:0]  rob_tag = '0;
    logic              issue_fire;
    logic [1:0]        issue_unit;
    logic [OPID_W-1:0] issue_op_id;
    logic [31:0]       issue_pc;
    logic [31:0]       issue_imm;
    logic [TAG_W-1:0]  issue_tag;
    logic [4:0]        issue_rd;
    logic [4:0]        issue_rs1;
    logic [4:0]        issue_rs2;
    logic              issue_rd_we;
    logic [2:0]        issue_rob_type;
    logic              issue_illegal;

    decode_issue_buffer #(.TAG_W(TAG_W), .OPID_W(OPID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
        .alu_full(alu_full), .br_full(br_full), .lsb_full(lsb_full),
        .rob_full(rob_full), .rob_tag(rob_tag),
        .issue_fire(issue_fire), .issue_unit(issue_unit), .issue_op_id(issue_op_id),
        .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_tag(issue_tag),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd_we(issue_rd_we), .issue_rob_type(issue_rob_type),
        .issue_illegal(issue_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  unit;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [2:0]  rt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic        last_ready, last_fire, last_we, last_ill;
    logic [1:0]  last_unit;
    logic [2:0]  last_rt;
    logic [4:0]  last_rd, last_rs1;
    logic [31:0] last_imm;
    logic [TAG_W-1:0] last_tag;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decoder built from the ISA field rules with integer arithmetic and lookup tables.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        op_id_t br_ops [8];
        op_id_t ld_ops [8];
        op_id_t st_ops [8];
        op_id_t ii_ops [8];
        op_id_t rb_ops [8];
        op_id_t ra_ops [8];
        int  f3 = int'(w[14:12]);
        int  f7 = int'(w[31:25]);
        int  imm_i = int'($signed(w) >>> 20);
        int  imm_s = (imm_i & ~31) | int'(w[11:7]);
        int  imm_b = ((int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1))
                     - (w[31] ? 4096 : 0);
        int  imm_j = ((int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1))
                     - (w[31] ? (1 << 20) : 0);
        bit  ok = 1'b0;
        bit  wr = 1'b0;
        bit  u1 = 1'b0;
        bit  u2 = 1'b0;
        br_ops = '{OP_BEQ, OP_BNE, OP_NOP, OP_NOP, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
        ld_ops = '{OP_LB, OP_LH, OP_LW, OP_NOP, OP_LBU, OP_LHU, OP_NOP, OP_NOP};
        st_ops = '{OP_SB, OP_SH, OP_SW, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP};
        ii_ops = '{OP_ADDI, OP_NOP, OP_SLTI, OP_SLTIU, OP_XORI, OP_NOP, OP_ORI, OP_ANDI};
        rb_ops = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
        ra_ops = '{OP_SUB, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_SRA, OP_NOP, OP_NOP};
        e = '{unit: 2'd0, op: OP_NOP, pc: pc, imm: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
              we: 1'b0, rt: 3'd0, ill: 1'b0};
        case (w[6:0])
            OPC_LUI:    begin ok = 1; wr = 1; e.unit = UNIT_ALU; e.op = OP_LUI;   e.imm = w & 32'hFFFFF000; end
            OPC_AUIPC:  begin ok = 1; wr = 1; e.unit = UNIT_ALU; e.op = OP_AUIPC; e.imm = w & 32'hFFFFF000; end
            OPC_JAL:    begin ok = 1; wr = 1; e.unit = UNIT_BR; e.op = OP_JAL; e.imm = 32'(imm_j); e.rt = 3'd4; end
            OPC_JALR:   begin ok = (f3 == 0); wr = 1; u1 = 1; e.unit = UNIT_BR; e.op = OP_JALR;
                              e.imm = 32'(imm_i); e.rt = 3'd4; end
            OPC_BRANCH: begin e.op = br_ops[f3]; ok = (e.op != OP_NOP); u1 = 1; u2 = 1;
                              e.unit = UNIT_BR; e.imm = 32'(imm_b); e.rt = 3'd1; end
            OPC_LOAD:   begin e.op = ld_ops[f3]; ok = (e.op != OP_NOP); wr = 1; u1 = 1;
                              e.unit = UNIT_LSB; e.imm = 32'(imm_i); e.rt = 3'd3; end
            OPC_STORE:  begin e.op = st_ops[f3]; ok = (e.op != OP_NOP); u1 = 1; u2 = 1;
                              e.unit = UNIT_LSB; e.imm = 32'(imm_s); e.rt = 3'd2; end
            OPC_OPIMM:  begin
                wr = 1; u1 = 1; e.unit = UNIT_ALU;
                if (f3 == 1) begin
                    ok = (f7 == 0); e.op = OP_SLLI; e.imm = 32'(w[24:20]);
                end else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 32); e.op = (f7 == 32) ? OP_SRAI : OP_SRLI;
                    e.imm = 32'(w[24:20]);
                end else begin
                    ok = 1; e.op = ii_ops[f3]; e.imm = 32'(imm_i);
                end
            end
            OPC_OP:     begin
                wr = 1; u1 = 1; u2 = 1; e.unit = UNIT_ALU;
                if (f7 == 0) e.op = rb_ops[f3];
                else if (f7 == 32) e.op = ra_ops[f3];
                else e.op = OP_NOP;
                ok = (e.op != OP_NOP);
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            return '{unit: 2'd0, op: OP_NOP, pc: pc, imm: 32'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                     we: 1'b0, rt: 3'd5, ill: 1'b1};
        end
        e.rd  = wr ? w[11:7] : 5'd0;
        e.rs1 = u1 ? w[19:15] : 5'd0;
        e.rs2 = u2 ? w[24:20] : 5'd0;
        e.we  = wr && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [127:0] pack_obs();
        return 128'({issue_unit, issue_op_id, issue_pc, issue_imm, issue_tag, issue_rd,
                     issue_rs1, issue_rs2, issue_rd_we, issue_rob_type, issue_illegal});
    endfunction

    // Called ~1ns after a falling edge with inputs already driven; compares, then advances the model
    // across the next rising edge.
    task automatic cycle(input string tag);
        exp_t h;
        bit   exp_ready, exp_fire, busy;
        logic [127:0] exp_vec;
        h = '{default: '0};
        #1;
        exp_ready = rst && rdy && !flush && (q.size() < DEPTH);
        exp_fire  = 1'b0;
        if (rst && rdy && !flush && q.size() > 0) begin
            h = q[0];
            busy = (h.unit == UNIT_ALU && alu_full) || (h.unit == UNIT_BR && br_full) ||
                   (h.unit == UNIT_LSB && lsb_full);
            exp_fire = !rob_full && !busy;
        end
        check_eq({tag, ":ready"}, 128'(iq_ready), 128'(exp_ready));
        check_eq({tag, ":fire"}, 128'(issue_fire), 128'(exp_fire));
        if (exp_fire)
            exp_vec = 128'({h.unit, h.op, h.pc, h.imm, rob_tag, h.rd, h.rs1, h.rs2, h.we, h.rt, h.ill});
        else
            exp_vec = '0;
        check_eq({tag, ":issue"}, pack_obs(), exp_vec);
        last_ready = iq_ready;   last_fire = issue_fire; last_unit = issue_unit;
        last_imm   = issue_imm;  last_rd   = issue_rd;   last_rs1  = issue_rs1;
        last_we    = issue_rd_we; last_tag = issue_tag;  last_rt   = issue_rob_type;
        last_ill   = issue_illegal;
        if (rdy) begin
            if (flush) begin
                q.delete();
            end else begin
                if (exp_fire) void'(q.pop_front());
                if (iq_valid && exp_ready) q.push_back(ref_decode(iq_inst, iq_pc));
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1; flush = 0; iq_valid = 0; alu_full = 0; br_full = 0; lsb_full = 0;
        rob_full = 0; rob_tag = '0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        iq_valid = 1; iq_inst = w; iq_pc = pc;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [9];
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        int r = $urandom_range(0, 3);
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                 OPC_OPIMM, OPC_OP};
        if (k < 9) w[6:0] = opcs[k];
        if (r == 0) w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #2;
        check_eq("reset_ready", 128'(iq_ready), 128'(0));
        check_eq("reset_issue", 128'({issue_fire, pack_obs()}), 128'(0));
        @(negedge clk); #1;
        rst = 1;

        // ADDI x5,x0,-1 issues one cycle after acceptance with tag 3
        idle(); rob_tag = 4'd3;
        push_word(32'hFFF00293, 32'h0000_0100);
        cycle("addi_push");
        iq_valid = 0;
        cycle("addi_issue");
        check_eq("addi_fire", 128'(last_fire), 128'(1));
        check_eq("addi_imm", 128'(last_imm), 128'(32'hFFFFFFFF));
        check_eq("addi_fields", 128'({last_unit, last_rd, last_we, last_rs1, last_tag, last_rt}),
                 128'({2'd1, 5'd5, 1'b1, 5'd0, 4'd3, 3'd0}));

        // LUI held behind a full ALU station; SW queues behind it
        idle(); alu_full = 1;
        push_word(32'h123450B7, 32'h0000_0200);
        cycle("lui_push");
        push_word(32'h0020A023, 32'h0000_0204);
        cycle("sw_push");
        check_eq("lui_hold1", 128'(last_fire), 128'(0));
        iq_valid = 0;
        push_word(32'h00000013, 32'h0000_0208);
        cycle("lui_hold");
        check_eq("lui_full_ready", 128'(last_ready), 128'(0));
        check_eq("lui_hold2", 128'(last_fire), 128'(0));
        iq_valid = 0;
        cycle("lui_hold3");
        alu_full = 0;
        cycle("lui_issue");
        check_eq("lui_fire", 128'(last_fire), 128'(1));
        check_eq("lui_imm", 128'({last_unit, last_imm}), 128'({2'd1, 32'h12345000}));
        cycle("sw_issue");
        check_eq("sw_fields", 128'({last_fire, last_unit, last_rt, last_rd}),
                 128'({1'b1, 2'd3, 3'd2, 5'd0}));

        // Flush with two entries buffered and an IQ entry offered
        idle(); rob_full = 1;
        push_word(32'h00100093, 32'h0000_0300); cycle("fl_fill0");
        push_word(32'h00200113, 32'h0000_0304); cycle("fl_fill1");
        rob_full = 0; flush = 1;
        push_word(32'h00300193, 32'h0000_0308);
        cycle("flush");
        check_eq("flush_noissue", 128'({last_fire, last_ready}), 128'(0));
        flush = 0; iq_valid = 0;
        cycle("post_flush");
        check_eq("post_flush_ready", 128'({last_ready, last_fire}), 128'({1'b1, 1'b0}));

        // BEQ x1,x2,-4 then ADD x0,x1,x2
        idle();
        push_word(32'hFE208EE3, 32'h0000_0400); cycle("beq_push");
        push_word(32'h00208033, 32'h0000_0404); cycle("beq_issue");
        check_eq("beq_fields", 128'({last_fire, last_unit, last_imm, last_rd, last_we, last_rt}),
                 128'({1'b1, 2'd2, 32'hFFFFFFFC, 5'd0, 1'b0, 3'd1}));
        iq_valid = 0;
        cycle("add_issue");
        check_eq("add_x0_we", 128'({last_fire, last_we}), 128'({1'b1, 1'b0}));

        // Illegal word issues regardless of station full flags
        idle(); alu_full = 1; br_full = 1; lsb_full = 1;
        push_word(32'h0000007F, 32'h0000_0500); cycle("ill_push");
        iq_valid = 0;
        cycle("ill_issue");
        check_eq("ill_fields", 128'({last_fire, last_ill, last_unit, last_rt, last_we}),
                 128'({1'b1, 1'b1, 2'd0, 3'd5, 1'b0}));

        // Asynchronous reset mid-stream with two entries buffered
        idle(); rob_full = 1;
        push_word(32'h00500093, 32'h0000_0600); cycle("rst_fill0");
        push_word(32'h00600113, 32'h0000_0604); cycle("rst_fill1");
        iq_valid = 0; rob_full = 0;
        rst = 0;
        #1;
        check_eq("rst_outputs", 128'({issue_fire, iq_ready, pack_obs()}), 128'(0));
        q.delete();
        @(negedge clk); #1;
        rst = 1;
        cycle("post_rst0");
        cycle("post_rst1");
        check_eq("post_rst_idle", 128'({last_ready, last_fire}), 128'({1'b1, 1'b0}));

        // Randomised traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            rdy      = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            iq_valid = ($urandom_range(0, 3) != 0);
            iq_inst  = rand_inst();
            iq_pc    = $urandom;
            alu_full = ($urandom_range(0, 3) == 0);
            br_full  = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            rob_full = ($urandom_range(0, 4) == 0);
            rob_tag  = TAG_W'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_buffer.md
Name: decode_issue_buffer

Overview:
Parametrised decode stage between the InstQueue and the ReorderBuffer/reservation stations.
- Decodes each accepted RV32I instruction and stores the decoded result in a small circular buffer.
- Issues the buffer head, in order, once the ROB and the target reservation station can both take it.
- Compared with the earlier purely combinational decoder, it adds:
  - a registered decoupling buffer;
  - flush support;
  - illegal-instruction flagging;
  - corrected unit steering (LUI goes to the ALU);
  - parametrised tag and buffer sizing.

Parameters:
TAG_W, 4, width of ROB tags.
OPID_W, 6, width of the op_id encoding from the shared package.
DEPTH, 2, number of buffer entries; must be a power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when low, all state freezes
flush  in  1  mispredict flush from the ROB
iq_valid  in  1  InstQueue entry available
iq_inst  in  32  instruction word
iq_pc  in  32  instruction pc
iq_ready  out  1  this block accepts the IQ entry this cycle
alu_full, br_full, lsb_full  in  1 each  reservation-station full flags
rob_full  in  1  ROB full
rob_tag  in  TAG_W  next free ROB tag
issue_fire  out  1  head issued this cycle; acts as the ROB/RS/RF allocate strobe
issue_unit  out  2  0 none, 1 ALU, 2 BR, 3 LSB
issue_op_id  out  OPID_W  operation id
issue_pc  out  32  instruction pc
issue_imm  out  32  decoded immediate
issue_tag  out  TAG_W  equals rob_tag
issue_rd, issue_rs1, issue_rs2  out  5 each  register indices (0 when unused)
issue_rd_we  out  1  instruction writes rd
issue_rob_type  out  3  ROB entry type
issue_illegal  out  1  instruction is illegal

Behaviour:
- Reset (rst=0, asynchronous): head, tail and count = 0; all entry valid bits = 0. All outputs are 0 whenever no issue occurs.
- Accept: iq_ready = rdy & ~flush & (count < DEPTH).
  - count is the registered value, so a slot freed by an issue in the same cycle is not reusable that cycle.
  - Push occurs when iq_valid & iq_ready.
- Decode is combinational on iq_inst and is registered into the tail entry at push.
- Unit steering:
  - ALU: LUI, AUIPC, OP, OP-IMM.
  - BR: JAL, JALR, BRANCH.
  - LSB: LOAD, STORE.
- ROB type codes: 0 register write (ALU class), 1 branch, 2 store, 3 load, 4 jump, 5 exception.
- Immediates:
  - I-type: sign-extended inst[31:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
  - B-type: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Shift-immediates: zero-extended inst[24:20].
  - R-type: 0.
- rs1 and rs2 are forced to 0 when the format does not use them. rd is 0 for BRANCH and STORE.
- rd_we = (format writes rd) & (rd != 0).
- Illegal instruction: unknown opcode, unknown funct3, or bad funct7 on OP/SLLI/SRLI/SRAI. Result:
  - issue_illegal = 1, op_id NOP, unit 0, rob_type 5, rd_we 0;
  - the entry still takes a ROB slot so the exception is raised at commit.
- Issue condition: count > 0 & rdy & ~flush & ~rob_full & ~(selected unit full).
  - Unit 0 needs only ROB space.
  - On issue, all issue_* outputs carry the head entry with issue_tag = rob_tag; head advances and wraps modulo DEPTH.
- Latency: at least one cycle from IQ accept to the earliest issue_fire.
- Simultaneous push and pop: count is unchanged; the head and tail pointers both advance.
- flush: at the next edge, count, head, tail and valid bits return to 0. No issue and no accept occur in the flush cycle.
- rdy=0: no state change; iq_ready = 0; issue_fire = 0.
- Order: issue is strictly in program order. A full unit at the head blocks all later entries; there is no bypass.

Decomposition:
- Shared package/defines holds:
  - opcode, funct3 and funct7 constants;
  - op_id codes, including NOP;
  - unit codes;
  - rob_type codes;
  - the decoded-entry struct (unit, op_id, pc, imm, rd, rs1, rs2, rd_we, rob_type, illegal).
- Natural sub-module: inst_decode_comb, the pure combinational decoder from instruction word to entry. The buffer, pointers and issue logic stay in decode_issue_buffer.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293) pushed with all stations empty and rob_tag=3 -> issue_fire one cycle later; unit ALU; imm 0xFFFFFFFF; rd 5; rd_we 1; rs1 0; tag 3; rob_type 0.
- LUI x1,0x12345 (0x123450B7) with alu_full=1 for 3 cycles -> issue held for those cycles; then it issues with unit ALU and imm 0x12345000. A following SW stays queued behind it; count reaches DEPTH and iq_ready drops.
- Fill 2 entries, then flush=1 with iq_valid=1 -> no issue and no accept that cycle; the next cycle count=0 and iq_ready=1.
- BEQ x1,x2,-4 (0xFE208EE3) -> unit BR; imm 0xFFFFFFFC; rd 0; rd_we 0; rob_type 1. Then ADD x0,x1,x2 -> rd_we 0.
- Illegal word 0x0000007F -> issue_illegal 1; unit 0; rob_type 5; issues even with all reservation stations full while rob_full=0.
- rst low asserted mid-stream with 2 entries buffered -> outputs 0 immediately; after release the buffer is empty and nothing issues.
